// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the icache refill path
// and the dcache refill/writeback path. Round-robin per transaction; a
// granted transaction owns the port until its last data beat completes.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_ready,
    output logic              ic_resp_valid,
    output logic [DATA_W-1:0] ic_resp_data,

    input  logic              dc_req_valid,
    input  logic              dc_req_rw,
    input  logic [ADDR_W-1:0] dc_req_addr,
    output logic              dc_req_ready,
    input  logic              dc_wdata_valid,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wdata_ready,
    output logic              dc_resp_valid,
    output logic [DATA_W-1:0] dc_resp_data,

    output logic              mem_req_valid,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    output logic              mem_wdata_valid,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wdata_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
);

    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WDATA,
        RDATA
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IC,
        OWN_DC
    } owner_t;

    state_t            state;
    owner_t            owner;
    owner_t            last_grant;
    logic [CNT_W-1:0]  beat_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;

    logic ic_win;
    logic dc_win;
    logic wr_beat;
    logic rd_beat;

    // Grant decision in IDLE: single requester wins, ties go to the one not granted last.
    always_comb begin
        ic_win = 1'b0;
        dc_win = 1'b0;
        if (!reset && state == IDLE) begin
            if (ic_req_valid && dc_req_valid) begin
                if (last_grant == OWN_IC) begin
                    dc_win = 1'b1;
                end else begin
                    ic_win = 1'b1;
                end
            end else begin
                ic_win = ic_req_valid;
                dc_win = dc_req_valid;
            end
        end
    end

    // Beat qualifiers: a write beat is a wdata handshake, a read beat is any memory response.
    always_comb begin
        wr_beat = !reset && (state == WDATA) && dc_wdata_valid && mem_wdata_ready;
        rd_beat = !reset && (state == RDATA) && mem_resp_valid;
    end

    // Output steering; everything is forced to zero while reset is high.
    always_comb begin
        ic_req_ready    = ic_win;
        dc_req_ready    = dc_win;
        ic_resp_valid   = 1'b0;
        ic_resp_data    = '0;
        dc_resp_valid   = 1'b0;
        dc_resp_data    = '0;
        dc_wdata_ready  = 1'b0;
        mem_req_valid   = 1'b0;
        mem_req_rw      = 1'b0;
        mem_req_addr    = '0;
        mem_wdata_valid = 1'b0;
        mem_wdata       = '0;
        if (!reset) begin
            case (state)
                ISSUE: begin
                    mem_req_valid = 1'b1;
                    mem_req_rw    = rw_q;
                    mem_req_addr  = addr_q;
                end
                WDATA: begin
                    mem_wdata_valid = dc_wdata_valid;
                    mem_wdata       = dc_wdata;
                    dc_wdata_ready  = mem_wdata_ready;
                end
                RDATA: begin
                    if (owner == OWN_IC) begin
                        ic_resp_valid = mem_resp_valid;
                        ic_resp_data  = mem_resp_data;
                    end else if (owner == OWN_DC) begin
                        dc_resp_valid = mem_resp_valid;
                        dc_resp_data  = mem_resp_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Transaction FSM: grant, issue the request, then count BEATS data beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            owner      <= OWN_NONE;
            last_grant <= OWN_IC;
            addr_q     <= '0;
            rw_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ic_win || dc_win) begin
                        owner      <= ic_win ? OWN_IC : OWN_DC;
                        last_grant <= ic_win ? OWN_IC : OWN_DC;
                        addr_q     <= ic_win ? ic_req_addr : dc_req_addr;
                        rw_q       <= dc_win && dc_req_rw;
                        beat_cnt   <= '0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        state <= rw_q ? WDATA : RDATA;
                    end
                end
                WDATA: begin
                    if (wr_beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= IDLE;
                            owner <= OWN_NONE;
                        end
                    end
                end
                RDATA: begin
                    if (rd_beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= IDLE;
                            owner <= OWN_NONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache refill path and the data-cache refill/writeback path of the 3-stage Riscv151 core.
- Each requester issues line-sized transactions of BEATS data words.
- Arbitration is round-robin per transaction; once granted, a transaction owns the memory port until its last beat completes.
- Sits between the icache/dcache miss controllers and the memory model/interconnect.

Parameters:
- ADDR_W, 32, address width of all request addresses.
- DATA_W, 32, width of one data beat.
- BEATS, 4, data beats per transaction; power of two, >=2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ic_req_valid  input  1  icache read request pending.
- ic_req_addr  input  ADDR_W  icache line address.
- ic_req_ready  output  1  icache request accepted this cycle.
- ic_resp_valid  output  1  icache read beat valid.
- ic_resp_data  output  DATA_W  icache read beat data.
- dc_req_valid  input  1  dcache request pending.
- dc_req_rw  input  1  dcache request type: 1 = write, 0 = read.
- dc_req_addr  input  ADDR_W  dcache line address.
- dc_req_ready  output  1  dcache request accepted this cycle.
- dc_wdata_valid  input  1  dcache write beat valid.
- dc_wdata  input  DATA_W  dcache write beat data.
- dc_wdata_ready  output  1  dcache write beat accepted.
- dc_resp_valid  output  1  dcache read beat valid.
- dc_resp_data  output  DATA_W  dcache read beat data.
- mem_req_valid  output  1  memory request valid.
- mem_req_rw  output  1  memory request type: 1 = write.
- mem_req_addr  output  ADDR_W  memory request address.
- mem_req_ready  input  1  memory accepts request.
- mem_wdata_valid  output  1  memory write beat valid.
- mem_wdata  output  DATA_W  memory write beat data.
- mem_wdata_ready  input  1  memory accepts write beat.
- mem_resp_valid  input  1  memory read beat valid.
- mem_resp_data  input  DATA_W  memory read beat data.

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous, active-high.
- Registers cleared by reset:
  - state = IDLE;
  - beat counter = 0;
  - owner = none;
  - last_grant = icache, so the dcache wins the first tie after reset.
- Output values while reset is high:
  - all *_valid and *_ready outputs are 0;
  - mem_req_addr, mem_wdata, ic_resp_data and dc_resp_data are 0.
- States: IDLE, ISSUE, WDATA, RDATA.
- IDLE, grant:
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester that is not last_grant is granted.
  - The winner's *_req_ready is high combinationally in this cycle only; the loser's is 0.
  - On the edge: latch addr and rw (icache rw forced to 0), set owner, update last_grant, clear the counter, go to ISSUE.
  - Requests are never accepted outside IDLE.
- ISSUE:
  - mem_req_valid = 1 with the latched addr and rw, held stable until mem_req_ready.
  - On the handshake edge: if rw = 1 go to WDATA, otherwise go to RDATA.
- WDATA:
  - Pass-through: mem_wdata_valid = dc_wdata_valid, mem_wdata = dc_wdata, dc_wdata_ready = mem_wdata_ready.
  - Each edge on which both valid and ready are 1 increments the counter.
  - The beat that brings the count to BEATS returns the state to IDLE.
  - Writes produce no response.
  - Outside WDATA, dc_wdata_ready = 0 and mem_wdata_valid = 0.
- RDATA:
  - mem_resp_valid/mem_resp_data are routed combinationally to the owner's *_resp_valid/*_resp_data.
  - The non-owner's resp_valid = 0.
  - Each mem_resp_valid beat increments the counter; the BEATS-th beat returns the state to IDLE.
  - Requesters cannot back-pressure read beats.
- mem_resp_valid outside RDATA is ignored: no routing, no counter change.
- Minimum transaction occupancy is 1 IDLE cycle + 1 ISSUE cycle + BEATS beat cycles, so back-to-back transactions have a 1-cycle IDLE gap.
- The counter is $clog2(BEATS)+1 bits wide and is cleared on every grant.
- Reset asserted mid-transaction: the transaction is dropped with no completion beats; the block is back in IDLE and able to grant on the first cycle after reset deasserts.
- A requester that drops *_req_valid before being granted is simply not granted.
- A request newly asserted during a busy period waits; once the block returns to IDLE, that request wins if the other requester is not also valid, and round-robin applies if both are.

Test Plan:
- Reset, then dc read addr 0x100 with BEATS = 4 and mem_req_ready = 1 -> dc_req_ready pulses in the IDLE cycle; mem_req_valid with addr 0x100 and rw = 0 the next cycle; 4 beats 0xA0..0xA3 appear on dc_resp_* and ic_resp_valid stays 0.
- ic and dc both valid continuously for 4 transactions -> grant order dc, ic, dc, ic; each grant is followed by exactly one ISSUE and 4 beats.
- dc write addr 0x200 with mem_wdata_ready toggling 1,0,1,0,... -> exactly 4 beats 0xW0..0xW3 cross, in order; the state returns to IDLE after the 4th handshake; no resp_valid pulses.
- mem_req_ready held 0 for 5 cycles during ISSUE -> mem_req_valid/addr/rw stay stable for all 5 cycles; no *_req_ready pulses; no grant changes.
- Spurious mem_resp_valid in IDLE, plus reset asserted after 2 of 4 read beats -> the spurious beat is not routed; after reset deasserts the block is in IDLE with all outputs 0, and a new ic request is granted on the first cycle.
- ic_req_valid dropped while the dc transaction is in progress, then reasserted -> no ic grant while the dc transaction is busy; ic is granted on the first IDLE cycle after the dc transaction ends.
